// File: rtl/qbus_pkg.sv
// qbus_pkg: state encoding, timeout counter width and timing defaults shared by
// the Q-bus arbiter and its reply-timeout counter.
package qbus_pkg;

    localparam int unsigned BUS_TIMEOUT_DEFAULT = 63;
    localparam int unsigned TMO_W               = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CPU_RD    = 3'd1,
        ST_CPU_WR    = 3'd2,
        ST_CPU_END   = 3'd3,
        ST_DMA_GRANT = 3'd4,
        ST_DMA_ACT   = 3'd5,
        ST_BUSERR    = 3'd6
    } state_t;

    // True while a CPU strobe is on the bus and a reply is being awaited.
    function automatic logic is_cpu_strobe(input state_t s);
        return (s == ST_CPU_RD) || (s == ST_CPU_WR);
    endfunction

endpackage

// File: rtl/qbus_timeout.sv
// qbus_timeout: ce-qualified down-counter that measures how long a CPU strobe
// has waited for RPLY. Only instantiated when QBUS_TIMEOUT_EN is defined.
module qbus_timeout
    import qbus_pkg::*;
#(
    parameter int unsigned LOAD_VALUE = BUS_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    input  logic load,
    input  logic dec,
    output logic zero,
    output logic expire
);

    localparam logic [TMO_W-1:0] LOAD_CNT = TMO_W'(LOAD_VALUE);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= LOAD_CNT;
        end else if (ce) begin
            if (load) begin
                count <= LOAD_CNT;
            end else if (dec && (count != '0)) begin
                count <= count - TMO_W'(1);
            end
        end
    end

    // expire marks the decrement that takes the count to zero, so the FSM can
    // leave the strobe state on that same edge.
    assign zero   = (count == '0);
    assign expire = dec && (count == TMO_W'(1));

endmodule

// File: rtl/qbus_arbiter.sv
// qbus_arbiter: registered Q-bus strobe sequencer arbitrating CPU DATI/DATO
// cycles against DMA (DMR/DMGO/SACK). Define QBUS_TIMEOUT_EN for reply timeout.
module qbus_arbiter
    import qbus_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    input  logic cpu_dati,
    input  logic cpu_dato,
    input  logic cpu_byte,
    output logic cpu_done,
    output logic cpu_error,
    output logic SYNC,
    output logic DIN,
    output logic DOUT,
    output logic WTBT,
    output logic BSY,
    input  logic RPLY,
    input  logic DMR,
    input  logic SACK,
    output logic DMGO
);

    if ((BUS_TIMEOUT < 1) || (BUS_TIMEOUT > 255)) begin : g_bad_timeout
        $error("qbus_arbiter: BUS_TIMEOUT must be in 1..255");
    end

    state_t state;

`ifdef QBUS_TIMEOUT_EN
    logic tmo_load;
    logic tmo_dec;
    logic tmo_zero;
    logic tmo_expire;
    logic tmo_hit;

    // The counter reloads whenever no strobe is out, so entry always starts full.
    assign tmo_load = !is_cpu_strobe(state);
    assign tmo_dec  = is_cpu_strobe(state) && !RPLY;
    assign tmo_hit  = tmo_expire || tmo_zero;

    qbus_timeout #(
        .LOAD_VALUE (BUS_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .load    (tmo_load),
        .dec     (tmo_dec),
        .zero    (tmo_zero),
        .expire  (tmo_expire)
    );
`else
    assign cpu_error = 1'b0;
`endif

    assign BSY = SYNC;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            SYNC     <= 1'b0;
            DIN      <= 1'b0;
            DOUT     <= 1'b0;
            WTBT     <= 1'b0;
            DMGO     <= 1'b0;
            cpu_done <= 1'b0;
`ifdef QBUS_TIMEOUT_EN
            cpu_error <= 1'b0;
`endif
        end else if (ce) begin
            // NOTE: non-blocking throughout; later branches override these defaults.
            cpu_done <= 1'b0;
`ifdef QBUS_TIMEOUT_EN
            cpu_error <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (DMR) begin
                        state <= ST_DMA_GRANT;
                        DMGO  <= 1'b1;
                    end else if (cpu_dati) begin
                        state <= ST_CPU_RD;
                        SYNC  <= 1'b1;
                        DIN   <= 1'b1;
                        WTBT  <= cpu_byte;
                    end else if (cpu_dato) begin
                        state <= ST_CPU_WR;
                        SYNC  <= 1'b1;
                        DOUT  <= 1'b1;
                        WTBT  <= cpu_byte;
                    end
                end

                ST_CPU_RD, ST_CPU_WR: begin
                    // A reply on the expiring cycle still counts as success.
                    if (RPLY) begin
                        state    <= ST_CPU_END;
                        SYNC     <= 1'b0;
                        DIN      <= 1'b0;
                        DOUT     <= 1'b0;
                        WTBT     <= 1'b0;
                        cpu_done <= 1'b1;
                    end
`ifdef QBUS_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state     <= ST_BUSERR;
                        SYNC      <= 1'b0;
                        DIN       <= 1'b0;
                        DOUT      <= 1'b0;
                        WTBT      <= 1'b0;
                        cpu_error <= 1'b1;
                    end
`endif
                end

                ST_CPU_END: begin
                    if (!RPLY) begin
                        state <= ST_IDLE;
                    end
                end

                ST_DMA_GRANT: begin
                    if (SACK) begin
                        state <= ST_DMA_ACT;
                        DMGO  <= 1'b0;
                    end else if (!DMR) begin
                        state <= ST_IDLE;
                        DMGO  <= 1'b0;
                    end
                end

                ST_DMA_ACT: begin
                    if (!SACK) begin
                        state <= ST_IDLE;
                    end
                end

`ifdef QBUS_TIMEOUT_EN
                ST_BUSERR: begin
                    state <= ST_IDLE;
                end
`endif

                default: begin
                    state <= ST_IDLE;
                    SYNC  <= 1'b0;
                    DIN   <= 1'b0;
                    DOUT  <= 1'b0;
                    WTBT  <= 1'b0;
                    DMGO  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qbus_arbiter.sv
// tb_qbus_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a bus-ownership reference model.
module tb_qbus_arbiter;

`ifdef QBUS_TIMEOUT_EN
    localparam int TMO    = 5;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 63;
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic ce       = 1'b0;
    logic cpu_dati = 1'b0;
    logic cpu_dato = 1'b0;
    logic cpu_byte = 1'b0;
    logic RPLY     = 1'b0;
    logic DMR      = 1'b0;
    logic SACK     = 1'b0;
    logic cpu_done, cpu_error, SYNC, DIN, DOUT, WTBT, BSY, DMGO;

    int errors = 0;
    int checks = 0;

    qbus_arbiter #(.BUS_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .cpu_dati  (cpu_dati),
        .cpu_dato  (cpu_dato),
        .cpu_byte  (cpu_byte),
        .cpu_done  (cpu_done),
        .cpu_error (cpu_error),
        .SYNC      (SYNC),
        .DIN       (DIN),
        .DOUT      (DOUT),
        .WTBT      (WTBT),
        .BSY       (BSY),
        .RPLY      (RPLY),
        .DMR       (DMR),
        .SACK      (SACK),
        .DMGO      (DMGO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the bus and how long the CPU has been waiting.
    bit m_cpu, m_wr, m_byte, m_release, m_err_ph, m_grant, m_dma, m_done, m_err;
    int m_waited;

    task automatic model_tick();
        if (!reset_n) begin
            m_cpu = 0; m_wr = 0; m_byte = 0; m_release = 0; m_err_ph = 0;
            m_grant = 0; m_dma = 0; m_done = 0; m_err = 0; m_waited = 0;
        end else if (ce) begin
            m_done = 0;
            m_err  = 0;
            if (m_cpu) begin
                m_waited++;
                if (RPLY) begin
                    m_cpu = 0; m_release = 1; m_done = 1;
                end else if (TMO_EN && m_waited >= TMO) begin
                    m_cpu = 0; m_err_ph = 1; m_err = 1;
                end
            end else if (m_release) begin
                m_release = RPLY;
            end else if (m_err_ph) begin
                m_err_ph = 0;
            end else if (m_grant) begin
                if (SACK) begin
                    m_grant = 0; m_dma = 1;
                end else if (!DMR) begin
                    m_grant = 0;
                end
            end else if (m_dma) begin
                m_dma = SACK;
            end else if (DMR) begin
                m_grant = 1;
            end else if (cpu_dati || cpu_dato) begin
                m_cpu = 1; m_wr = !cpu_dati; m_byte = cpu_byte; m_waited = 0;
            end
        end
    endtask

    function automatic logic [7:0] model_out();
        return {m_done, m_err, m_cpu, m_cpu && !m_wr, m_cpu && m_wr, m_cpu && m_byte, m_cpu, m_grant};
    endfunction

    function automatic logic [7:0] outs();
        return {cpu_done, cpu_error, SYNC, DIN, DOUT, WTBT, BSY, DMGO};
    endfunction

    task automatic step(input string tag);
        @(posedge clk);
        model_tick();
        @(negedge clk);
        check(tag, outs(), model_out());
    endtask

    int n_sync, n_err, n_done;

    initial begin
        // Reset with ce low must still clear everything.
        reset_n = 0; ce = 0;
        step("rst_a");
        step("rst_b");
        check("reset_outs", outs(), 8'h00);
        ce = 1;
        step("rst_c");
        reset_n = 1;
        step("idle");

        // Read, RPLY after two strobe cycles.
        cpu_dati = 1;
        step("rd_c1"); check("rd_strobe1", {SYNC, DIN, DOUT, BSY}, 4'b1101);
        step("rd_c2"); check("rd_strobe2", {SYNC, DIN}, 2'b11);
        RPLY = 1;
        step("rd_c3"); check("rd_done", {cpu_done, SYNC, DIN}, 3'b100);
        cpu_dati = 0; RPLY = 0;
        step("rd_c4"); check("rd_done_once", cpu_done, 1'b0);
        step("rd_idle"); check("rd_idle", outs(), 8'h00);

        // Byte write, RPLY held long; a new read must wait for RPLY release.
        cpu_dato = 1; cpu_byte = 1;
        step("wr_c1"); check("wr_strobe", {SYNC, DIN, DOUT, WTBT}, 4'b1011);
        RPLY = 1;
        step("wr_c2"); check("wr_done", {cpu_done, SYNC, WTBT}, 3'b100);
        cpu_dato = 0; cpu_byte = 0; cpu_dati = 1;
        for (int i = 0; i < 4; i++) begin
            step("wr_hold");
            check("wr_hold_nosync", {SYNC, cpu_done}, 2'b00);
        end
        RPLY = 0;
        step("wr_release"); check("wr_release", SYNC, 1'b0);
        step("rd2_c1"); check("rd2_start", {SYNC, DIN}, 2'b11);
        RPLY = 1;
        step("rd2_c2");
        cpu_dati = 0; RPLY = 0;
        step("rd2_c3");

        // DMR and read together: DMA wins, read runs after SACK drops.
        DMR = 1; cpu_dati = 1;
        step("dma_c1"); check("dma_grant", {DMGO, SYNC}, 2'b10);
        SACK = 1; DMR = 0;
        step("dma_c2"); check("dma_act", {DMGO, SYNC}, 2'b00);
        RPLY = 1;
        step("dma_c3"); check("dma_rply_ignored", {SYNC, cpu_done}, 2'b00);
        RPLY = 0; SACK = 0;
        step("dma_c4"); check("dma_release", SYNC, 1'b0);
        step("dma_c5"); check("dma_then_read", {SYNC, DIN}, 2'b11);
        RPLY = 1;
        step("dma_c6");
        cpu_dati = 0; RPLY = 0;
        step("dma_c7");

        // Withdrawn DMR pulse.
        DMR = 1;
        step("wd_c1"); check("wd_grant", DMGO, 1'b1);
        DMR = 0;
        step("wd_c2"); check("wd_drop", outs(), 8'h00);
        step("wd_c3"); check("wd_idle", outs(), 8'h00);

        // Reset in the middle of a write with ce low.
        cpu_dato = 1;
        step("rw_c1"); check("rw_strobe", {SYNC, DOUT}, 2'b11);
        ce = 0; reset_n = 0;
        step("rw_c2"); check("rw_reset", outs(), 8'h00);
        reset_n = 1; ce = 1; cpu_dato = 0;
        step("rw_c3"); check("rw_idle", outs(), 8'h00);

`ifdef QBUS_TIMEOUT_EN
        // No reply at all: bus error after TMO strobe cycles.
        n_sync = 0; n_err = 0; n_done = 0;
        cpu_dati = 1;
        for (int i = 0; i < TMO + 4; i++) begin
            step("to_run");
            if (SYNC) n_sync++;
            if (cpu_done) n_done++;
            if (cpu_error) begin
                n_err++;
                cpu_dati = 0;
            end
        end
        check("to_sync_len", n_sync, TMO);
        check("to_err_once", n_err, 1);
        check("to_no_done", n_done, 0);

        // Reply on the last allowed cycle wins over the timeout.
        cpu_dati = 1;
        for (int i = 0; i < TMO; i++) step("to_edge_wait");
        RPLY = 1;
        step("to_edge"); check("to_edge_done", {cpu_done, cpu_error}, 2'b10);
        cpu_dati = 0; RPLY = 0;
        step("to_edge_b");
        step("to_edge_c");
`endif

        // Randomized traffic with a well-behaved CPU and loosely-behaved DMA/slave.
        for (int i = 0; i < 3000; i++) begin
            ce      = ($urandom_range(0, 3) != 0);
            reset_n = ($urandom_range(0, 199) != 0);
            if (!reset_n || cpu_done || cpu_error) begin
                cpu_dati = 0; cpu_dato = 0;
            end else if (!cpu_dati && !cpu_dato && ($urandom_range(0, 2) == 0)) begin
                case ($urandom_range(0, 3))
                    0:       begin cpu_dati = 1; cpu_dato = 1; end
                    1:       cpu_dato = 1;
                    default: cpu_dati = 1;
                endcase
                cpu_byte = $urandom_range(0, 1) == 1;
            end
            RPLY = ($urandom_range(0, 2) == 0);
            DMR  = ($urandom_range(0, 9) == 0) || (DMGO && ($urandom_range(0, 3) != 0));
            SACK = (DMGO && ($urandom_range(0, 2) == 0)) || (SACK && ($urandom_range(0, 4) != 0))
                   || ($urandom_range(0, 49) == 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qbus_arbiter.md
QBUS_ARBITER -- requirements
Module: qbus_arbiter

Interface
REQ-001 Parameter BUS_TIMEOUT, default 63, is the number of ce-qualified cycles to wait for RPLY before a bus error; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  reset; synchronous, active-low.
REQ-004 ce  input  1  clock enable; state advances only when ce=1.
REQ-005 cpu_dati  input  1  CPU read request, level, held until cpu_done or cpu_error.
REQ-006 cpu_dato  input  1  CPU write request, level, held until cpu_done or cpu_error.
REQ-007 cpu_byte  input  1  byte/odd-address qualifier for the CPU cycle.
REQ-008 cpu_done  output  1  one-ce-cycle pulse: CPU transfer completed by RPLY.
REQ-009 cpu_error  output  1  one-ce-cycle pulse: CPU transfer aborted by timeout.
REQ-010 SYNC, DIN, DOUT, WTBT, BSY  output  1 each  bus strobes; BSY equals SYNC.
REQ-011 RPLY  input  1  slave reply.
REQ-012 DMR  input  1  DMA request; SACK  input  1  DMA active; DMGO  output  1  DMA grant.

Function
REQ-013 States: IDLE, CPU_RD, CPU_WR, CPU_END, DMA_GRANT, DMA_ACT, BUSERR. All outputs are registered.
REQ-014 IDLE priority: DMR=1 goes to DMA_GRANT; otherwise cpu_dati goes to CPU_RD; otherwise cpu_dato goes to CPU_WR. If cpu_dati and cpu_dato are both 1, read wins.
REQ-015 SYNC/DIN (CPU_RD) or SYNC/DOUT (CPU_WR) are 1 starting in the first cycle after the request is sampled in IDLE. WTBT is latched from cpu_byte on entry and held for the whole cycle.
REQ-016 CPU_RD/CPU_WR with RPLY=1: go to CPU_END, drop SYNC/DIN/DOUT/WTBT, pulse cpu_done for one cycle.
REQ-017 CPU_END: stay while RPLY=1; go to IDLE when RPLY=0. A new request is not started before the slave releases RPLY.
REQ-018 Minimum CPU transaction is 3 ce cycles (IDLE→CPU_xx→CPU_END→IDLE) when RPLY=1 on the first strobe cycle.
REQ-019 DMA_GRANT: DMGO=1, no strobes driven. SACK=1 goes to DMA_ACT with DMGO=0. DMR=0 with SACK=0 goes to IDLE (withdrawn request).
REQ-020 DMA_ACT: all CPU strobes stay 0 and CPU requests are held pending. SACK=0 goes to IDLE.
REQ-021 DMR is ignored outside IDLE. A CPU cycle in progress is never preempted.
REQ-022 Asserting RPLY in IDLE or DMA states has no effect.
REQ-023 cpu_done and cpu_error are never 1 in the same cycle.

Reset
REQ-024 reset_n=0 at a clock edge, regardless of ce: state goes to IDLE; SYNC, DIN, DOUT, WTBT, BSY, DMGO, cpu_done and cpu_error go to 0; the timeout counter loads BUS_TIMEOUT.
REQ-025 Reset mid-transaction drops all strobes on the same edge. No cpu_done or cpu_error is issued for the aborted cycle.

Configuration
REQ-026 Macro QBUS_TIMEOUT_EN, when defined: the counter loads BUS_TIMEOUT on entry to CPU_RD/CPU_WR and decrements each ce cycle while RPLY=0.
REQ-027 With QBUS_TIMEOUT_EN defined, reaching 0 goes to BUSERR: strobes drop, cpu_error pulses for one cycle, then IDLE.
REQ-028 With QBUS_TIMEOUT_EN defined, RPLY arriving in the same cycle the counter reaches 0 counts as success (cpu_done).
REQ-029 Without QBUS_TIMEOUT_EN: no counter, no BUSERR state, cpu_error is constant 0, and CPU cycles wait indefinitely for RPLY.

Structure
REQ-030 Package qbus_pkg holds the state encoding constants and the BUS_TIMEOUT default.
REQ-031 The timeout counter is the sub-module qbus_timeout (load, ce, decrement, zero flag). It is instantiated only under QBUS_TIMEOUT_EN.
REQ-032 The block replaces the combinational strobe generation in the CPU top level and connects the DMR/DMGO/SACK pins.

Verification
REQ-033 cpu_dati=1, RPLY rises 2 cycles after SYNC → SYNC=DIN=1 for 2 cycles, cpu_done pulses once, then IDLE after RPLY=0.
REQ-034 cpu_dato=1, cpu_byte=1, RPLY held high 4 extra cycles → WTBT=1 during the strobe, state holds CPU_END until RPLY falls.
REQ-035 DMR and cpu_dati rise in the same IDLE cycle → DMGO=1; SACK=1 → DMGO=0, no SYNC; SACK=0 → the CPU read starts the next cycle.
REQ-036 QBUS_TIMEOUT_EN, BUS_TIMEOUT=5, no RPLY → strobes drop after 5 ce cycles, cpu_error pulses once, cpu_done stays 0.
REQ-037 reset_n=0 during CPU_WR with ce=0 → all outputs 0 on the next edge, state IDLE.
REQ-038 DMR pulse withdrawn before SACK → DMGO=1 then 0, return to IDLE, no strobes.
